// File: rtl/output_pack_writer_pkg.sv
// Shared CNN write-back parameters and state encodings.
// Used by the output_pack_writer controller and its lane_packer datapath.
package output_pack_writer_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_LANES  = 4;
    localparam int DEF_ADR_W  = 10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } opw_state_t;

    function automatic int lane_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/output_pack_writer_lane_packer.sv
// Lane storage for one memory word: indexed write, zero-pad above the
// written lane on the final beat, and whole-word clear.
module lane_packer
    import output_pack_writer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES,
    parameter int LW     = lane_idx_w(DEF_LANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic                    i_wr,
    input  logic                    i_pad,
    input  logic [LW-1:0]           i_idx,
    input  logic [DATA_W-1:0]       i_data,
    output logic [DATA_W*LANES-1:0] o_word
);

    logic [LANES-1:0][DATA_W-1:0] r_lane;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_lane <= '0;
        end else if (i_wr) begin
            for (int l = 0; l < LANES; l++) begin
                if (l == int'(i_idx)) begin
                    r_lane[l] <= i_data;
                end else if (i_pad && (l > int'(i_idx))) begin
                    r_lane[l] <= '0;
                end
            end
        end
    end

    assign o_word = r_lane;

endmodule

// File: rtl/output_pack_writer.sv
// Packs LANES results per word and writes them to memory with a
// valid/grant handshake; tracks word count and address wrap per run.
module output_pack_writer
    import output_pack_writer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES,
    parameter int ADR_W  = DEF_ADR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADR_W-1:0]        baseAdr,
    input  logic                    inValid,
    input  logic [DATA_W-1:0]       inData,
    input  logic                    inLast,
    output logic                    inReady,
    input  logic                    memGnt,
    output logic                    weMem,
    output logic [ADR_W-1:0]        memAdr,
    output logic [DATA_W*LANES-1:0] memData,
    output logic                    busy,
    output logic                    done,
    output logic [ADR_W-1:0]        wordCnt,
    output logic                    adrWrap
);

    localparam int LW = lane_idx_w(LANES);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    opw_state_t       r_state;
    opw_state_t       w_next;
    logic [LW-1:0]    r_lane_cnt;
    logic             r_last;
    logic [ADR_W-1:0] r_adr;
    logic [ADR_W-1:0] r_cnt;
    logic             r_wrap;

    logic w_start;
    logic w_acc;
    logic w_gnt;
    logic w_pad;
    logic w_end;

    assign w_start = (r_state == S_IDLE) && start;
    assign w_acc   = (r_state == S_COLLECT) && inValid;
    assign w_gnt   = (r_state == S_WRITE) && memGnt;
    assign w_end   = inLast || (r_lane_cnt == LAST_LANE);
    assign w_pad   = w_acc && inLast && (r_lane_cnt != LAST_LANE);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (start) w_next = S_COLLECT;
            S_COLLECT: if (w_acc && w_end) w_next = S_WRITE;
            S_WRITE: begin
                if (memGnt) w_next = r_last ? S_DONE : S_COLLECT;
            end
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_lane_cnt <= '0;
            r_last     <= 1'b0;
            r_adr      <= '0;
            r_cnt      <= '0;
            r_wrap     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_adr      <= baseAdr;
                r_cnt      <= '0;
                r_wrap     <= 1'b0;
                r_lane_cnt <= '0;
                r_last     <= 1'b0;
            end
            if (w_acc) begin
                r_lane_cnt <= r_lane_cnt + 1'b1;
                if (inLast) r_last <= 1'b1;
            end
            // Grant retires the word; wrap is sticky until next start.
            if (w_gnt) begin
                r_adr      <= r_adr + 1'b1;
                r_cnt      <= r_cnt + 1'b1;
                r_lane_cnt <= '0;
                r_last     <= 1'b0;
                if (&r_adr) r_wrap <= 1'b1;
            end
        end
    end

    lane_packer #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .LW     (LW)
    ) u_lanes (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_start || w_gnt),
        .i_wr   (w_acc),
        .i_pad  (w_pad),
        .i_idx  (r_lane_cnt),
        .i_data (inData),
        .o_word (memData)
    );

    assign inReady = (r_state == S_COLLECT);
    assign weMem   = (r_state == S_WRITE);
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign memAdr  = r_adr;
    assign wordCnt = r_cnt;
    assign adrWrap = r_wrap;

endmodule

// File: tb/tb_output_pack_writer.sv
// Directed scoreboard bench for output_pack_writer.
module tb_output_pack_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  baseAdr = '0;
    logic        inValid = 1'b0;
    logic [7:0]  inData = '0;
    logic        inLast = 1'b0;
    logic        inReady;
    logic        memGnt = 1'b1;
    logic        weMem;
    logic [9:0]  memAdr;
    logic [31:0] memData;
    logic        busy;
    logic        done;
    logic [9:0]  wordCnt;
    logic        adrWrap;

    typedef struct {
        logic [9:0]  adr;
        logic [31:0] data;
    } wr_t;

    wr_t q[$];
    int  checks = 0;
    int  failures = 0;
    int  done_cnt = 0;
    logic acc = 1'b0;

    always #5 clk = ~clk;

    output_pack_writer dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .baseAdr (baseAdr),
        .inValid (inValid),
        .inData  (inData),
        .inLast  (inLast),
        .inReady (inReady),
        .memGnt  (memGnt),
        .weMem   (weMem),
        .memAdr  (memAdr),
        .memData (memData),
        .busy    (busy),
        .done    (done),
        .wordCnt (wordCnt),
        .adrWrap (adrWrap)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, write port scored here.
    task automatic cyc();
        wr_t e;
        @(negedge clk);
        acc = inValid && inReady;
        if (done) done_cnt++;
        if (weMem && memGnt && !rst) begin
            chk("wr_expected", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("wr_adr", 64'(memAdr), 64'(e.adr));
                chk("wr_data", 64'(memData), 64'(e.data));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_words(input logic [9:0] base, input int first,
                                input int n);
        logic [9:0]  a;
        logic [31:0] w;
        wr_t e;
        a = base;
        w = '0;
        for (int i = 0; i < n; i++) begin
            w[8*(i%4) +: 8] = 8'(first + i);
            if ((i % 4 == 3) || (i == n - 1)) begin
                e.adr = a;
                e.data = w;
                q.push_back(e);
                a = a + 10'd1;
                w = '0;
            end
        end
    endtask

    task automatic do_start(input logic [9:0] base);
        baseAdr = base;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        inValid = 1'b1;
        inData = d;
        inLast = l;
        do begin
            cyc();
            n++;
        end while (!acc && n < 50);
        chk("beat_accepted", 64'(acc), 64'd1);
        inValid = 1'b0;
        inLast = 1'b0;
    endtask

    task automatic beats(input int first, input int n, input logic l);
        for (int i = 0; i < n; i++)
            beat(8'(first + i), l && (i == n - 1));
    endtask

    task automatic wait_done(input string tag);
        int n0;
        n0 = done_cnt;
        for (int i = 0; i < 20 && done_cnt == n0; i++) cyc();
        cyc();
        cyc();
        chk({tag, "_done_once"}, 64'(done_cnt - n0), 64'd1);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        chk({tag, "_sb_empty"}, 64'(q.size()), 64'd0);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_we"}, 64'(weMem), 64'd0);
        chk({tag, "_rdy"}, 64'(inReady), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_adr"}, 64'(memAdr), 64'd0);
        chk({tag, "_data"}, 64'(memData), 64'd0);
        chk({tag, "_cnt"}, 64'(wordCnt), 64'd0);
        chk({tag, "_wrap"}, 64'(adrWrap), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk_idle_zero("reset");

        // Two full words, last on a full word.
        expect_words(10'h010, 8'h01, 8);
        do_start(10'h010);
        beats(8'h01, 8, 1'b1);
        wait_done("run1");
        chk("run1_cnt", 64'(wordCnt), 64'd2);
        chk("run1_adr", 64'(memAdr), 64'h012);
        chk("run1_wrap", 64'(adrWrap), 64'd0);

        // Partial final word is zero-padded.
        expect_words(10'h020, 8'h11, 6);
        do_start(10'h020);
        beats(8'h11, 6, 1'b1);
        wait_done("run2");
        chk("run2_cnt", 64'(wordCnt), 64'd2);

        // Grant stall, ignored start and ignored beats in WRITE.
        expect_words(10'h040, 8'h21, 5);
        memGnt = 1'b0;
        do_start(10'h040);
        beat(8'h21, 1'b0);
        baseAdr = 10'h100;
        start = 1'b1;
        beat(8'h22, 1'b0);
        start = 1'b0;
        beats(8'h23, 2, 1'b0);
        chk("lat_we", 64'(weMem), 64'd1);
        inValid = 1'b1;
        inData = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            chk("stall_we", 64'(weMem), 64'd1);
            chk("stall_rdy", 64'(inReady), 64'd0);
            chk("stall_adr", 64'(memAdr), 64'h040);
            chk("stall_data", 64'(memData), 64'h24232221);
            cyc();
        end
        inValid = 1'b0;
        memGnt = 1'b1;
        cyc();
        chk("stall_cnt", 64'(wordCnt), 64'd1);
        beat(8'h25, 1'b1);
        wait_done("run3");
        chk("run3_cnt", 64'(wordCnt), 64'd2);
        chk("run3_adr", 64'(memAdr), 64'h042);

        // Address wrap.
        expect_words(10'h3FF, 8'h31, 8);
        do_start(10'h3FF);
        beats(8'h31, 4, 1'b0);
        cyc();
        chk("wrap_set", 64'(adrWrap), 64'd1);
        chk("wrap_adr", 64'(memAdr), 64'h000);
        beats(8'h35, 4, 1'b1);
        wait_done("run4");
        chk("run4_wrap", 64'(adrWrap), 64'd1);
        chk("run4_adr", 64'(memAdr), 64'h001);

        // Reset during a granted WRITE drops the write.
        memGnt = 1'b0;
        do_start(10'h050);
        chk("run5_wrap_clr", 64'(adrWrap), 64'd0);
        beats(8'h41, 4, 1'b0);
        chk("run5_in_write", 64'(weMem), 64'd1);
        memGnt = 1'b1;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_idle_zero("rst_write");
        expect_words(10'h060, 8'h51, 2);
        do_start(10'h060);
        chk("run6_adr", 64'(memAdr), 64'h060);
        beats(8'h51, 2, 1'b1);
        wait_done("run6");
        chk("run6_cnt", 64'(wordCnt), 64'd1);
        chk("run6_adr_end", 64'(memAdr), 64'h061);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
